// File: rtl/jedro_1_decode_stage_pkg.sv
// Shared RV32I decode constants, unit codes, immediate formats and the decoded packet type.
package jedro_1_decode_stage_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;
  localparam int RLEN = 5;
  localparam int OPW  = 4;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    UNIT_NONE   = 3'd0,
    UNIT_ALU    = 3'd1,
    UNIT_LSU    = 3'd2,
    UNIT_BRANCH = 3'd3,
    UNIT_JAL    = 3'd4,
    UNIT_JALR   = 3'd5,
    UNIT_SYSTEM = 3'd6
  } unit_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    BUF_EMPTY, BUF_ONE, BUF_TWO
  } buf_state_e;

  typedef struct packed {
    logic [ALEN-1:0] pc;
    unit_e           unit;
    logic [OPW-1:0]  alu_op;
    logic [RLEN-1:0] rs1;
    logic [RLEN-1:0] rs2;
    logic            rs1_used;
    logic            rs2_used;
    logic [RLEN-1:0] rd;
    logic            rd_we;
    logic [XLEN-1:0] imm;
    logic [3:0]      lsu_ctrl;
    logic            illegal;
  } dec_pkt_t;

endpackage

// File: rtl/jedro_1_decode_stage_imm_gen.sv
// Combinational immediate extraction and sign extension for the I/S/B/U/J formats.
module jedro_1_decode_stage_imm_gen
  import jedro_1_decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                      instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                      instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/jedro_1_decode_stage.sv
// Registered RV32I decode stage with a 2-entry (main + skid) output buffer; 1-cycle latency.
// Optional JEDRO_1_RV32E_EN: any used register index >= 16 is flagged illegal.
module jedro_1_decode_stage
  import jedro_1_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [DATA_WIDTH-1:0]     instr_rdata_i,
  input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [ADDR_WIDTH-1:0]     dec_pc_o,
  output logic [2:0]                dec_unit_o,
  output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic                      rs1_used_o,
  output logic                      rs2_used_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [3:0]                lsu_ctrl_o,
  output logic                      illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = instr_rdata_i[6:0];
  assign f3     = instr_rdata_i[14:12];
  assign f7     = instr_rdata_i[31:25];

  unit_e      unit;
  imm_fmt_e   fmt;
  logic       rs1u, rs2u, wr, ill;
  logic [3:0] alu_op, lsu;
  logic [XLEN-1:0] imm;
  dec_pkt_t   pkt_new;

  jedro_1_decode_stage_imm_gen u_imm_gen (
    .instr_i (instr_rdata_i),
    .fmt_i   (fmt),
    .imm_o   (imm)
  );

  always_comb begin
    unit   = UNIT_NONE;
    fmt    = IMM_NONE;
    rs1u   = 1'b0;
    rs2u   = 1'b0;
    wr     = 1'b0;
    ill    = 1'b0;
    alu_op = {1'b0, f3};
    lsu    = 4'b0000;
    case (opcode)
      OPC_LUI:    begin unit = UNIT_ALU; fmt = IMM_U; wr = 1'b1; end
      OPC_AUIPC:  begin unit = UNIT_ALU; fmt = IMM_U; wr = 1'b1; alu_op = 4'b0000; end
      OPC_JAL:    begin unit = UNIT_JAL; fmt = IMM_J; wr = 1'b1; alu_op = 4'b0000; end
      OPC_JALR: begin
        unit = UNIT_JALR; fmt = IMM_I; rs1u = 1'b1; wr = 1'b1; alu_op = 4'b0000;
        ill  = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        unit = UNIT_BRANCH; fmt = IMM_B; rs1u = 1'b1; rs2u = 1'b1;
        ill  = (f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        unit = UNIT_LSU; fmt = IMM_I; rs1u = 1'b1; wr = 1'b1; alu_op = 4'b0000;
        lsu  = {1'b0, f3};
        ill  = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        unit = UNIT_LSU; fmt = IMM_S; rs1u = 1'b1; rs2u = 1'b1; alu_op = 4'b0000;
        lsu  = {1'b1, f3};
        ill  = (f3 > 3'b010);
      end
      OPC_OP_IMM: begin
        unit = UNIT_ALU; fmt = IMM_I; rs1u = 1'b1; wr = 1'b1;
        if (f3 == 3'b101) alu_op = {instr_rdata_i[30], f3};
        // Shift-immediates reuse the upper imm bits as funct7, so they must be well-formed.
        if (f3 == 3'b001)      ill = (f7 != F7_BASE);
        else if (f3 == 3'b101) ill = (f7 != F7_BASE) && (f7 != F7_ALT);
      end
      OPC_OP: begin
        unit   = UNIT_ALU; rs1u = 1'b1; rs2u = 1'b1; wr = 1'b1;
        alu_op = {instr_rdata_i[30], f3};
        ill    = !((f7 == F7_BASE) ||
                   ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_MISC_MEM: unit = UNIT_SYSTEM;
      OPC_SYSTEM: begin
        unit = UNIT_SYSTEM; fmt = IMM_I;
        rs1u = (f3 != 3'b000) && !f3[2];
        wr   = (f3 != 3'b000);
      end
      default: ill = 1'b1;
    endcase
    if (instr_rdata_i[1:0] != 2'b11) ill = 1'b1;
`ifdef JEDRO_1_RV32E_EN
    if ((rs1u && instr_rdata_i[19]) || (rs2u && instr_rdata_i[24]) || (wr && instr_rdata_i[11]))
      ill = 1'b1;
`endif
  end

  always_comb begin
    pkt_new          = '0;
    pkt_new.pc       = instr_addr_i;
    pkt_new.unit     = ill ? UNIT_NONE : unit;
    pkt_new.alu_op   = alu_op;
    pkt_new.rs1      = instr_rdata_i[19:15];
    pkt_new.rs2      = instr_rdata_i[24:20];
    pkt_new.rs1_used = rs1u && !ill;
    pkt_new.rs2_used = rs2u && !ill;
    pkt_new.rd       = instr_rdata_i[11:7];
    pkt_new.rd_we    = wr && !ill && (instr_rdata_i[11:7] != 5'd0);
    pkt_new.imm      = imm;
    pkt_new.lsu_ctrl = lsu;
    pkt_new.illegal  = ill;
  end

  buf_state_e state_q;
  logic       ready_q;
  dec_pkt_t   main_q, skid_q;
  logic       accept, pop;

  assign accept = instr_valid_i && ready_q;
  assign pop    = dec_valid_o && dec_ready_i;

  // Ready is registered from the next buffer state so it never depends on dec_ready_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= BUF_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      ready_q <= !((state_q == BUF_ONE && accept && !pop) || (state_q == BUF_TWO && !pop));
      case (state_q)
        BUF_EMPTY: if (accept) begin main_q <= pkt_new; state_q <= BUF_ONE; end
        BUF_ONE: begin
          if (accept && !pop)      begin skid_q <= pkt_new; state_q <= BUF_TWO; end
          else if (!accept && pop) state_q <= BUF_EMPTY;
          else if (accept && pop)  main_q <= pkt_new;
        end
        BUF_TWO: if (pop) begin main_q <= skid_q; state_q <= BUF_ONE; end
        default: state_q <= BUF_EMPTY;
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign dec_valid_o   = (state_q != BUF_EMPTY);
  assign dec_pc_o      = main_q.pc;
  assign dec_unit_o    = main_q.unit;
  assign alu_op_sel_o  = main_q.alu_op;
  assign rs1_addr_o    = main_q.rs1;
  assign rs2_addr_o    = main_q.rs2;
  assign rs1_used_o    = main_q.rs1_used;
  assign rs2_used_o    = main_q.rs2_used;
  assign rd_addr_o     = main_q.rd;
  assign rd_we_o       = main_q.rd_we;
  assign imm_o         = main_q.imm;
  assign lsu_ctrl_o    = main_q.lsu_ctrl;
  assign illegal_o     = main_q.illegal;

endmodule

// File: tb/tb_jedro_1_decode_stage.sv
// Directed bench for jedro_1_decode_stage: decode fields, buffering order, flush and reset.
module tb_jedro_1_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_rdata_i;
  logic [31:0] instr_addr_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_pc_o;
  logic [2:0]  dec_unit_o;
  logic [3:0]  alu_op_sel_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        rs1_used_o, rs2_used_o, rd_we_o;
  logic [31:0] imm_o;
  logic [3:0]  lsu_ctrl_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  jedro_1_decode_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_rdata_i (instr_rdata_i),
    .instr_addr_i  (instr_addr_i),
    .dec_valid_o   (dec_valid_o),
    .dec_ready_i   (dec_ready_i),
    .dec_pc_o      (dec_pc_o),
    .dec_unit_o    (dec_unit_o),
    .alu_op_sel_o  (alu_op_sel_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_used_o    (rs1_used_o),
    .rs2_used_o    (rs2_used_o),
    .rd_addr_o     (rd_addr_o),
    .rd_we_o       (rd_we_o),
    .imm_o         (imm_o),
    .lsu_ctrl_o    (lsu_ctrl_o),
    .illegal_o     (illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] pc);
    instr_valid_i = 1'b1;
    instr_rdata_i = w;
    instr_addr_i  = pc;
    step();
    instr_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0;
    instr_rdata_i = '0; instr_addr_i = '0; dec_ready_i = 1'b0;
    repeat (2) step();
    check("rst_valid", {31'd0, dec_valid_o}, 32'd0);
    check("rst_ready", {31'd0, instr_ready_o}, 32'd0);
    check("rst_pc", dec_pc_o, 32'd0);
    check("rst_imm", imm_o, 32'd0);
    rst_i = 1'b0;
    step();
    check("ready_after_rst", {31'd0, instr_ready_o}, 32'd1);

    dec_ready_i = 1'b1;
    push(32'hFFB10093, 32'h100);  // ADDI x1,x2,-5
    check("addi_valid", {31'd0, dec_valid_o}, 32'd1);
    check("addi_pc", dec_pc_o, 32'h100);
    check("addi_rs1", {27'd0, rs1_addr_o}, 32'd2);
    check("addi_rd", {27'd0, rd_addr_o}, 32'd1);
    check("addi_imm", imm_o, 32'hFFFFFFFB);
    check("addi_op", {28'd0, alu_op_sel_o}, 32'h0);
    check("addi_unit", {29'd0, dec_unit_o}, 32'd1);
    check("addi_rd_we", {31'd0, rd_we_o}, 32'd1);
    check("addi_rs2_used", {31'd0, rs2_used_o}, 32'd0);

    push(32'h40725193, 32'h104);  // SRAI x3,x4,7
    check("srai_op", {28'd0, alu_op_sel_o}, 32'hD);
    check("srai_imm", imm_o, 32'h00000407);
    check("srai_illegal", {31'd0, illegal_o}, 32'd0);
    check("srai_rd", {27'd0, rd_addr_o}, 32'd3);

    push(32'h00000000, 32'h108);
    check("zero_illegal", {31'd0, illegal_o}, 32'd1);
    check("zero_unit", {29'd0, dec_unit_o}, 32'd0);
    check("zero_rd_we", {31'd0, rd_we_o}, 32'd0);
    check("zero_valid", {31'd0, dec_valid_o}, 32'd1);

    push(32'h02208033, 32'h10C);  // MUL x0,x1,x2 (not in RV32I)
    check("mul_illegal", {31'd0, illegal_o}, 32'd1);
    check("mul_unit", {29'd0, dec_unit_o}, 32'd0);
    check("mul_rs_used", {30'd0, rs1_used_o, rs2_used_o}, 32'd0);
    check("mul_pc", dec_pc_o, 32'h10C);

    push(32'h00532423, 32'h110);  // SW x5,8(x6)
    check("sw_unit", {29'd0, dec_unit_o}, 32'd2);
    check("sw_lsu", {28'd0, lsu_ctrl_o}, 32'hA);
    check("sw_imm", imm_o, 32'd8);
    check("sw_rs2", {27'd0, rs2_addr_o}, 32'd5);
    check("sw_rd_we", {31'd0, rd_we_o}, 32'd0);

    push(32'h123452B7, 32'h114);  // LUI x5,0x12345
    check("lui_imm", imm_o, 32'h12345000);
    check("lui_rd_we", {31'd0, rd_we_o}, 32'd1);

    push(32'hFE208CE3, 32'h118);  // BEQ x1,x2,-8
    check("beq_imm", imm_o, 32'hFFFFFFF8);
    check("beq_unit", {29'd0, dec_unit_o}, 32'd3);
    check("beq_rs2_used", {31'd0, rs2_used_o}, 32'd1);

    push(32'h00208833, 32'h11C);  // ADD x16,x1,x2
`ifdef JEDRO_1_RV32E_EN
    check("add_x16_illegal", {31'd0, illegal_o}, 32'd1);
    check("add_x16_rd_we", {31'd0, rd_we_o}, 32'd0);
`else
    check("add_x16_illegal", {31'd0, illegal_o}, 32'd0);
    check("add_x16_rd_we", {31'd0, rd_we_o}, 32'd1);
`endif
    step();
    check("drain_valid", {31'd0, dec_valid_o}, 32'd0);

    // Stall: three back-to-back words, only two fit.
    dec_ready_i = 1'b0;
    instr_valid_i = 1'b1; instr_rdata_i = 32'hFFB10093;
    instr_addr_i = 32'h200; step();
    instr_addr_i = 32'h204; step();
    instr_addr_i = 32'h208;
    check("full_ready", {31'd0, instr_ready_o}, 32'd0);
    check("full_pc", dec_pc_o, 32'h200);
    repeat (2) step();
    check("stall_pc_stable", dec_pc_o, 32'h200);
    check("stall_valid", {31'd0, dec_valid_o}, 32'd1);
    dec_ready_i = 1'b1;
    step();
    check("order_2nd", dec_pc_o, 32'h204);
    check("ready_reopen", {31'd0, instr_ready_o}, 32'd1);
    step();
    instr_valid_i = 1'b0;
    check("order_3rd", dec_pc_o, 32'h208);
    check("order_3rd_valid", {31'd0, dec_valid_o}, 32'd1);
    step();
    check("stall_drained", {31'd0, dec_valid_o}, 32'd0);

    // Flush while full with a word presented.
    dec_ready_i = 1'b0;
    instr_valid_i = 1'b1;
    instr_addr_i = 32'h300; step();
    instr_addr_i = 32'h304; step();
    instr_addr_i = 32'h308; flush_i = 1'b1; step();
    flush_i = 1'b0; instr_valid_i = 1'b0;
    check("flush_two_valid", {31'd0, dec_valid_o}, 32'd0);
    check("flush_two_ready", {31'd0, instr_ready_o}, 32'd1);
    step();
    check("flush_two_lost", {31'd0, dec_valid_o}, 32'd0);

    // Flush with a real handshake in the same cycle.
    instr_valid_i = 1'b1;
    instr_addr_i = 32'h400; step();
    instr_addr_i = 32'h404; flush_i = 1'b1; step();
    flush_i = 1'b0; instr_valid_i = 1'b0;
    check("flush_hs_valid", {31'd0, dec_valid_o}, 32'd0);
    step();
    check("flush_hs_lost", {31'd0, dec_valid_o}, 32'd0);

    // Asynchronous reset while a packet is stalled.
    push(32'hFFB10093, 32'h500);
    check("pre_rst_valid", {31'd0, dec_valid_o}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, dec_valid_o}, 32'd0);
    check("async_rst_ready", {31'd0, instr_ready_o}, 32'd0);
    step();
    rst_i = 1'b0;
    step();
    check("post_rst_ready", {31'd0, instr_ready_o}, 32'd1);
    check("post_rst_valid", {31'd0, dec_valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
